// File: rtl/alu_share_arbiter.sv
// +----------------------------------------------------------------------------+
// | alu_share_arbiter: one 32-bit ALU shared by two requesters, round-robin    |
// | grant, one-entry tagged result buffer. Optional macro: ALU_ARB_STATS_EN.   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module alu_share_arbiter #(
  parameter int WIDTH = 32,
  parameter int OPW   = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0_valid,
  input  logic [OPW-1:0]   req0_op,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  output logic             req0_ack,
  input  logic             req1_valid,
  input  logic [OPW-1:0]   req1_op,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             req1_ack,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic             resp_id,
  output logic [WIDTH-1:0] resp_c,
  output logic             resp_zero
`ifdef ALU_ARB_STATS_EN
  ,
  output logic [15:0]      grant_cnt0,
  output logic [15:0]      grant_cnt1
`endif
);

  localparam logic [0:0] ST_EMPTY = 1'b0;
  localparam logic [0:0] ST_FULL  = 1'b1;

  localparam logic [OPW-1:0] OP_ADD = OPW'(0);
  localparam logic [OPW-1:0] OP_SUB = OPW'(1);
  localparam logic [OPW-1:0] OP_OR  = OPW'(2);
  localparam logic [OPW-1:0] OP_SLT = OPW'(3);

  logic [0:0]       state_q, state_d;
  logic             prio_q, prio_d;
  logic             resp_id_q, resp_id_d;
  logic [WIDTH-1:0] resp_c_q, resp_c_d;
  logic             resp_zero_q, resp_zero_d;

  logic             w_can_accept;
  logic             w_grant0;
  logic             w_grant1;
  logic             w_grant;
  logic [OPW-1:0]   w_op;
  logic [WIDTH-1:0] w_a;
  logic [WIDTH-1:0] w_b;
  logic [WIDTH-1:0] w_alu_c;
  logic             w_alu_zero;

  // A stalled full buffer blocks new grants; a draining one can be refilled.
  always_comb begin
    w_can_accept = (state_q == ST_EMPTY) || resp_ready;
    w_grant0 = w_can_accept && req0_valid && (!req1_valid || !prio_q);
    w_grant1 = w_can_accept && req1_valid && (!req0_valid || prio_q);
    w_grant  = w_grant0 || w_grant1;
  end

  assign req0_ack = w_grant0;
  assign req1_ack = w_grant1;

  always_comb begin
    w_op = w_grant1 ? req1_op : req0_op;
    w_a  = w_grant1 ? req1_a  : req0_a;
    w_b  = w_grant1 ? req1_b  : req0_b;
  end

  always_comb begin
    w_alu_c = '0;
    case (w_op)
      OP_ADD:  w_alu_c = w_a + w_b;
      OP_SUB:  w_alu_c = w_a - w_b;
      OP_OR:   w_alu_c = w_a | w_b;
      OP_SLT:  w_alu_c = {{(WIDTH-1){1'b0}}, (w_a < w_b)};
      default: w_alu_c = '0;
    endcase
    w_alu_zero = (w_a == w_b);
  end

  always_comb begin
    state_d     = state_q;
    prio_d      = prio_q;
    resp_id_d   = resp_id_q;
    resp_c_d    = resp_c_q;
    resp_zero_d = resp_zero_q;
    if (w_grant) begin
      state_d     = ST_FULL;
      prio_d      = ~w_grant1;
      resp_id_d   = w_grant1;
      resp_c_d    = w_alu_c;
      resp_zero_d = w_alu_zero;
    end else if ((state_q == ST_FULL) && resp_ready) begin
      state_d = ST_EMPTY;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_EMPTY;
      prio_q      <= 1'b0;
      resp_id_q   <= 1'b0;
      resp_c_q    <= '0;
      resp_zero_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      prio_q      <= prio_d;
      resp_id_q   <= resp_id_d;
      resp_c_q    <= resp_c_d;
      resp_zero_q <= resp_zero_d;
    end
  end

  assign resp_valid = (state_q == ST_FULL);
  assign resp_id    = resp_id_q;
  assign resp_c     = resp_c_q;
  assign resp_zero  = resp_zero_q;

`ifdef ALU_ARB_STATS_EN
  logic [15:0] cnt0_q, cnt0_d;
  logic [15:0] cnt1_q, cnt1_d;

  // Saturating grant counters.
  always_comb begin
    cnt0_d = cnt0_q;
    cnt1_d = cnt1_q;
    if (w_grant0 && (cnt0_q != 16'hFFFF)) cnt0_d = cnt0_q + 16'd1;
    if (w_grant1 && (cnt1_q != 16'hFFFF)) cnt1_d = cnt1_q + 16'd1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt0_q <= '0;
      cnt1_q <= '0;
    end else begin
      cnt0_q <= cnt0_d;
      cnt1_q <= cnt1_d;
    end
  end

  assign grant_cnt0 = cnt0_q;
  assign grant_cnt1 = cnt1_q;
`else
`endif

endmodule

`default_nettype wire

// File: tb/tb_alu_share_arbiter.sv
// Directed vector bench for alu_share_arbiter.
`default_nettype none

module tb_alu_share_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0_valid, req1_valid;
  logic [2:0]  req0_op, req1_op;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic        req0_ack, req1_ack;
  logic        resp_valid, resp_ready, resp_id, resp_zero;
  logic [31:0] resp_c;
`ifdef ALU_ARB_STATS_EN
  logic [15:0] grant_cnt0, grant_cnt1;
`endif

  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  alu_share_arbiter #(.WIDTH(32), .OPW(3)) dut (
    .clk        (clk),
    .reset      (reset),
    .req0_valid (req0_valid),
    .req0_op    (req0_op),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req0_ack   (req0_ack),
    .req1_valid (req1_valid),
    .req1_op    (req1_op),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .req1_ack   (req1_ack),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_id    (resp_id),
    .resp_c     (resp_c),
    .resp_zero  (resp_zero)
`ifdef ALU_ARB_STATS_EN
    ,
    .grant_cnt0 (grant_cnt0),
    .grant_cnt1 (grant_cnt1)
`endif
  );

  typedef struct {
    logic        v0;
    logic [2:0]  op0;
    logic [31:0] a0, b0;
    logic        v1;
    logic [2:0]  op1;
    logic [31:0] a1, b1;
    logic        e_ack0, e_ack1;
    logic        e_valid, e_id;
    logic [31:0] e_c;
    logic        e_zero;
  } vec_t;

  vec_t vecs[14];

  function automatic vec_t mk(input logic v0, input logic [2:0] op0, input logic [31:0] a0, input logic [31:0] b0,
                              input logic v1, input logic [2:0] op1, input logic [31:0] a1, input logic [31:0] b1,
                              input logic e_ack0, input logic e_ack1, input logic e_valid, input logic e_id,
                              input logic [31:0] e_c, input logic e_zero);
    vec_t v;
    v.v0 = v0; v.op0 = op0; v.a0 = a0; v.b0 = b0;
    v.v1 = v1; v.op1 = op1; v.a1 = a1; v.b1 = b1;
    v.e_ack0 = e_ack0; v.e_ack1 = e_ack1; v.e_valid = e_valid; v.e_id = e_id;
    v.e_c = e_c; v.e_zero = e_zero;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
    else n_pass++;
  endtask

  task automatic set_req(input logic v0, input logic [2:0] op0, input logic [31:0] a0, input logic [31:0] b0,
                         input logic v1, input logic [2:0] op1, input logic [31:0] a1, input logic [31:0] b1);
    req0_valid = v0; req0_op = op0; req0_a = a0; req0_b = b0;
    req1_valid = v1; req1_op = op1; req1_a = a1; req1_b = b1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
  endtask

  initial begin
    // ADD=0 SUB=1 OR=2 SLT=3
    vecs[0]  = mk(1, 3'd0, 32'hFFFF_FFFF, 32'h1, 0, 3'd0, 0, 0,        1, 0, 1, 0, 32'h0, 0);
    vecs[1]  = mk(1, 3'd1, 32'd5, 32'd7, 0, 3'd0, 0, 0,                1, 0, 1, 0, 32'hFFFF_FFFE, 0);
    vecs[2]  = mk(1, 3'd3, 32'h1, 32'h8000_0000, 0, 3'd0, 0, 0,        1, 0, 1, 0, 32'h1, 0);
    vecs[3]  = mk(1, 3'd7, 32'd3, 32'd3, 0, 3'd0, 0, 0,                1, 0, 1, 0, 32'h0, 1);
    vecs[4]  = mk(0, 3'd0, 0, 0, 1, 3'd2, 32'hF0, 32'h0F,              0, 1, 1, 1, 32'hFF, 0);
    vecs[5]  = mk(1, 3'd0, 32'd2, 32'd3, 1, 3'd1, 32'd10, 32'd4,       1, 0, 1, 0, 32'd5, 0);
    vecs[6]  = mk(1, 3'd0, 32'd2, 32'd3, 1, 3'd1, 32'd10, 32'd4,       0, 1, 1, 1, 32'd6, 0);
    vecs[7]  = mk(1, 3'd0, 32'd2, 32'd3, 1, 3'd1, 32'd10, 32'd4,       1, 0, 1, 0, 32'd5, 0);
    vecs[8]  = mk(1, 3'd0, 32'd2, 32'd3, 1, 3'd1, 32'd10, 32'd4,       0, 1, 1, 1, 32'd6, 0);
    vecs[9]  = mk(1, 3'd2, 32'h1200, 32'h0034, 0, 3'd0, 0, 0,          1, 0, 1, 0, 32'h1234, 0);
    vecs[10] = mk(0, 3'd0, 0, 0, 0, 3'd0, 0, 0,                        0, 0, 0, 0, 32'h0, 0);
    vecs[11] = mk(1, 3'd0, 32'd2, 32'd3, 1, 3'd1, 32'd10, 32'd4,       0, 1, 1, 1, 32'd6, 0);
    vecs[12] = mk(0, 3'd0, 0, 0, 1, 3'd3, 32'h8000_0000, 32'h1,        0, 1, 1, 1, 32'h0, 0);
    vecs[13] = mk(0, 3'd0, 0, 0, 0, 3'd0, 0, 0,                        0, 0, 0, 0, 32'h0, 0);

    reset = 1'b0;
    resp_ready = 1'b1;
    set_req(0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    tick();
    chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("rst_resp_id", {31'd0, resp_id}, 32'd0);
    chk("rst_resp_c", resp_c, 32'd0);
    chk("rst_resp_zero", {31'd0, resp_zero}, 32'd0);
    reset = 1'b1;
    tick();

    for (int i = 0; i < 14; i++) begin
      set_req(vecs[i].v0, vecs[i].op0, vecs[i].a0, vecs[i].b0, vecs[i].v1, vecs[i].op1, vecs[i].a1, vecs[i].b1);
      #1;
      chk($sformatf("v%0d_ack0", i), {31'd0, req0_ack}, {31'd0, vecs[i].e_ack0});
      chk($sformatf("v%0d_ack1", i), {31'd0, req1_ack}, {31'd0, vecs[i].e_ack1});
      tick();
      chk($sformatf("v%0d_valid", i), {31'd0, resp_valid}, {31'd0, vecs[i].e_valid});
      if (vecs[i].e_valid) begin
        chk($sformatf("v%0d_id", i), {31'd0, resp_id}, {31'd0, vecs[i].e_id});
        chk($sformatf("v%0d_c", i), resp_c, vecs[i].e_c);
        chk($sformatf("v%0d_zero", i), {31'd0, resp_zero}, {31'd0, vecs[i].e_zero});
      end
    end

    // Backpressure: buffer holds req1's OR result while req0 waits.
    resp_ready = 1'b0;
    set_req(0, 0, 0, 0, 1, 3'd2, 32'hF0, 32'h0F);
    #1;
    chk("bp_ack1_empty", {31'd0, req1_ack}, 32'd1);
    tick();
    chk("bp_valid", {31'd0, resp_valid}, 32'd1);
    chk("bp_c", resp_c, 32'hFF);
    set_req(1, 3'd0, 32'd1, 32'd1, 0, 0, 0, 0);
    for (int k = 0; k < 3; k++) begin
      #1;
      chk($sformatf("bp_stall%0d_ack0", k), {31'd0, req0_ack}, 32'd0);
      tick();
      chk($sformatf("bp_stall%0d_c", k), resp_c, 32'hFF);
      chk($sformatf("bp_stall%0d_id", k), {31'd0, resp_id}, 32'd1);
    end
    resp_ready = 1'b1;
    #1;
    chk("bp_release_ack0", {31'd0, req0_ack}, 32'd1);
    tick();
    chk("bp_release_c", resp_c, 32'd2);
    chk("bp_release_id", {31'd0, resp_id}, 32'd0);
    chk("bp_release_zero", {31'd0, resp_zero}, 32'd1);
    set_req(0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    chk("bp_drain_valid", {31'd0, resp_valid}, 32'd0);

    // Asynchronous reset while FULL; prio is 1 here (last grant was req0).
    resp_ready = 1'b0;
    set_req(1, 3'd0, 32'd7, 32'd8, 0, 0, 0, 0);
    tick();
    set_req(0, 0, 0, 0, 0, 0, 0, 0);
    chk("mr_full", {31'd0, resp_valid}, 32'd1);
    #2;
    reset = 1'b0;
    #1;
    chk("mr_async_valid", {31'd0, resp_valid}, 32'd0);
    chk("mr_async_c", resp_c, 32'd0);
    tick();
    reset = 1'b1;
    resp_ready = 1'b1;
    set_req(1, 3'd0, 32'd1, 32'd2, 1, 3'd0, 32'd3, 32'd4);
    #1;
    chk("mr_after_ack0", {31'd0, req0_ack}, 32'd1);
    chk("mr_after_ack1", {31'd0, req1_ack}, 32'd0);
    tick();
    chk("mr_after_c", resp_c, 32'd3);
    set_req(0, 0, 0, 0, 0, 0, 0, 0);
    tick();

`ifdef ALU_ARB_STATS_EN
    do_reset();
    set_req(1, 3'd0, 32'd1, 32'd1, 0, 0, 0, 0);
    for (int k = 0; k < 3; k++) tick();
    set_req(0, 0, 0, 0, 1, 3'd0, 32'd1, 32'd1);
    for (int k = 0; k < 2; k++) tick();
    set_req(0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    chk("stats_cnt0", {16'd0, grant_cnt0}, 32'd3);
    chk("stats_cnt1", {16'd0, grant_cnt1}, 32'd2);
    set_req(1, 3'd0, 32'd1, 32'd1, 0, 0, 0, 0);
    for (int k = 0; k < 65532; k++) tick();
    chk("stats_cnt0_max", {16'd0, grant_cnt0}, 32'hFFFF);
    tick();
    chk("stats_cnt0_sat", {16'd0, grant_cnt0}, 32'hFFFF);
    chk("stats_cnt1_hold", {16'd0, grant_cnt1}, 32'd2);
    set_req(0, 0, 0, 0, 0, 0, 0, 0);
    tick();
`else
    do_reset();
    tick();
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
- Shares one 32-bit ALU datapath (ADD/SUB/OR/SLT, zero flag) between two requesters.
- Requesters are, for example, the main datapath and a branch/address helper unit.
- Arbitration is round-robin with a valid/ack request handshake.
- The result goes into a one-entry registered output buffer with valid/ready backpressure and a tag naming the requester it belongs to.

Parameters:
- WIDTH, 32, operand/result width.
- OPW, 3, ALU opcode width.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- req0_valid  input  1  requester 0 has an operation pending.
- req0_op  input  OPW  requester 0 opcode.
- req0_a  input  WIDTH  requester 0 operand A.
- req0_b  input  WIDTH  requester 0 operand B.
- req0_ack  output  1  requester 0 operation accepted this cycle.
- req1_valid / req1_op / req1_a / req1_b / req1_ack  same as above, for requester 1.
- resp_valid  output  1  result buffer holds a valid result.
- resp_ready  input  1  consumer takes the result this cycle.
- resp_id  output  1  requester that owns the result.
- resp_c  output  WIDTH  ALU result.
- resp_zero  output  1  set when A==B for that operation.

Behaviour:
- Reset (reset=0, asynchronous):
  - resp_valid=0, resp_id=0, resp_c=0, resp_zero=0.
  - Round-robin pointer prio=0 (requester 0 favoured).
  - FSM enters EMPTY.
- Opcodes:
  - 000 ADD: A+B, wraps mod 2^WIDTH.
  - 001 SUB: A-B, wraps mod 2^WIDTH.
  - 010 OR: A|B.
  - 011 SLT: 1 if A<B as an unsigned compare, else 0.
  - 100-111: result 0. Never X.
- zero = (A==B), independent of opcode.
- FSM states:
  - EMPTY: buffer free.
  - FULL: buffer holds an unconsumed result.
- Accept condition: can_accept = (state==EMPTY) | (state==FULL & resp_ready).
- Grant (combinational, same cycle):
  - If can_accept and only one reqN_valid is high, grant that requester.
  - If both are high, grant requester prio.
  - reqN_ack=1 for exactly the granted requester, in the same cycle. It is never asserted when can_accept=0.
  - Requesters hold valid/op/a/b stable until they see ack.
- On a grant edge:
  - The ALU result, zero flag and id are captured into the buffer.
  - resp_valid=1 from the next cycle. Latency: ack in cycle N, resp_valid in N+1.
  - prio := ~granted_id. This applies only on grant edges; prio is unchanged when only the response drains.
- Transitions:
  - EMPTY + grant → FULL.
  - EMPTY + no grant → EMPTY.
  - FULL + resp_ready + grant → FULL, buffer replaced. Full throughput: one op per cycle while resp_ready=1.
  - FULL + resp_ready + no grant → EMPTY, resp_valid=0.
  - FULL + !resp_ready → FULL. Outputs stay stable and no acks are issued.
- Reset mid-operation: a buffered result is discarded; the pending requester must re-request.
- Outputs resp_* change only on clock edges. Acks are combinational from the valids and state.

Optional Feature:
- Macro: ALU_ARB_STATS_EN.
- When defined, adds two output ports:
  - grant_cnt0 output 16: count of grants to requester 0.
  - grant_cnt1 output 16: count of grants to requester 1.
- Counters increment on each grant edge, saturate at 16'hFFFF, and reset to 0.
- When not defined, these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Single-requester ops (resp_ready=1):
  - After reset, req0 ADD a=32'hFFFF_FFFF, b=1 → ack0 same cycle; next cycle resp_valid=1, resp_id=0, resp_c=0, resp_zero=0.
  - Then SUB 5-7 → resp_c=32'hFFFF_FFFE.
  - Then SLT 1 vs 32'h8000_0000 → resp_c=1.
  - Then opcode 111 → resp_c=0.
- Contention (resp_ready=1): both valid continuously for 4 cycles → grants alternate 0,1,0,1; resp_id follows the same sequence one cycle later.
- Backpressure:
  - resp_ready=0 with req1 OR 32'hF0 | 32'h0F → result 32'hFF is buffered.
  - For 3 cycles with req0 valid: ack0=0 and resp_c stays 32'hFF.
  - resp_ready=1 → ack0 in that cycle; next cycle shows req0's result.
- Drain without a new request: FULL with resp_ready=1 and no valids → resp_valid=0 next cycle and prio unchanged.
- Reset mid-operation: assert reset while FULL, asynchronously between edges → resp_valid drops to 0 immediately, before the next clock; after release, simultaneous requests grant req0 first.
- With ALU_ARB_STATS_EN defined: 3 grants to req0 and 2 to req1 → grant_cnt0=3, grant_cnt1=2. Force grant_cnt0 to 16'hFFFF, then grant → stays 16'hFFFF.
